// File: rtl/hnf_sram_ctl.sv
// hnf_sram_ctl
// Request front-end for one single-port hnf_sram instance in the HN-F data/tag store.
// Write and read requests share the single SRAM port through a round-robin arbiter.
// Read data comes back through a 2-entry response FIFO that can take backpressure.
// A credit check on reads means the FIFO can never overflow.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o             write request handshake (wr_ready_o = grant)
//   wr_addr_i, wr_data_i              write address / data
//   rd_valid_i/rd_ready_o             read request handshake (rd_ready_o = grant)
//   rd_addr_i, rd_id_i                read address / tag
//   rsp_valid_o/rsp_ready_i           response FIFO head handshake
//   rsp_data_o, rsp_id_o              response data / tag at the FIFO head
//   sram_we_o, sram_addr_o,
//   sram_data_in_o, sram_data_out_i   SRAM port
//   busy_o                            read in flight or response FIFO non-empty
module hnf_sram_ctl #(
    parameter int RAM_ADDR_WIDTH = 14,
    parameter int RAM_DATA_WIDTH = 512,
    parameter int RD_ID_WIDTH    = 8,
    parameter int RD_LATENCY     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [RAM_DATA_WIDTH-1:0] wr_data_i,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [RD_ID_WIDTH-1:0]    rd_id_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [RAM_DATA_WIDTH-1:0] rsp_data_o,
    output logic [RD_ID_WIDTH-1:0]    rsp_id_o,
    output logic                      sram_we_o,
    output logic [RAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] sram_data_in_o,
    input  logic [RAM_DATA_WIDTH-1:0] sram_data_out_i,
    output logic                      busy_o
);

    logic                      rd_prio_q, rd_prio_d;
    logic [1:0]                buf_count_q, buf_count_d;
    logic                      buf_wr_ptr_q, buf_rd_ptr_q;
    logic [RAM_DATA_WIDTH-1:0] buf_data_q [2];
    logic [RD_ID_WIDTH-1:0]    buf_id_q   [2];

    logic                      wr_elig_s, rd_elig_s;
    logic                      wr_gnt_s, rd_gnt_s;
    logic                      inflight_s;
    logic                      push_s, pop_s;
    logic [RD_ID_WIDTH-1:0]    push_id_s;
    logic [2:0]                credit_used_s;

    // Outstanding reads = buffered responses plus the one possibly still inside the SRAM.
    assign credit_used_s = {1'b0, buf_count_q} + {2'b00, inflight_s};
    // Requests are masked during reset so SRAM_WE stays low and nothing is accepted.
    assign wr_elig_s     = wr_valid_i && !rst_i;
    assign rd_elig_s     = rd_valid_i && !rst_i && (credit_used_s < 3'd2);

    // Arbitration: round-robin on conflict, pointer moves only when both sides compete.
    always_comb begin
        wr_gnt_s  = 1'b0;
        rd_gnt_s  = 1'b0;
        rd_prio_d = rd_prio_q;
        if (wr_elig_s && rd_elig_s) begin
            if (rd_prio_q) begin
                rd_gnt_s  = 1'b1;
                rd_prio_d = 1'b0;
            end else begin
                wr_gnt_s  = 1'b1;
                rd_prio_d = 1'b1;
            end
        end else if (wr_elig_s) begin
            wr_gnt_s = 1'b1;
        end else if (rd_elig_s) begin
            rd_gnt_s = 1'b1;
        end else begin
            wr_gnt_s = 1'b0;
            rd_gnt_s = 1'b0;
        end
    end

    assign wr_ready_o = wr_gnt_s;
    assign rd_ready_o = rd_gnt_s;

    // SRAM port drive in the grant cycle; data input is zero unless writing.
    always_comb begin
        sram_we_o      = 1'b0;
        sram_addr_o    = {RAM_ADDR_WIDTH{1'b0}};
        sram_data_in_o = {RAM_DATA_WIDTH{1'b0}};
        if (wr_gnt_s) begin
            sram_we_o      = 1'b1;
            sram_addr_o    = wr_addr_i;
            sram_data_in_o = wr_data_i;
        end else if (rd_gnt_s) begin
            sram_addr_o    = rd_addr_i;
        end else begin
            sram_we_o      = 1'b0;
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            // Zero-latency SRAM: data is valid in the grant cycle itself.
            assign inflight_s = 1'b0;
            assign push_s     = rd_gnt_s;
            assign push_id_s  = rd_id_i;
        end else begin : g_lat1
            logic                   inflight_q;
            logic [RD_ID_WIDTH-1:0] inflight_id_q;

            // Track the single read travelling through the registered SRAM output.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    inflight_q    <= 1'b0;
                    inflight_id_q <= {RD_ID_WIDTH{1'b0}};
                end else begin
                    inflight_q    <= rd_gnt_s;
                    inflight_id_q <= rd_gnt_s ? rd_id_i : inflight_id_q;
                end
            end

            assign inflight_s = inflight_q;
            assign push_s     = inflight_q;
            assign push_id_s  = inflight_id_q;
        end
    endgenerate

    assign pop_s = (buf_count_q != 2'd0) && rsp_ready_i;

    // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        buf_count_d = buf_count_q;
        case ({push_s, pop_s})
            2'b10:   buf_count_d = buf_count_q + 2'd1;
            2'b01:   buf_count_d = buf_count_q - 2'd1;
            default: buf_count_d = buf_count_q;
        endcase
    end

    // Control state: arbiter pointer (read wins first conflict) and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_prio_q    <= 1'b1;
            buf_count_q  <= 2'd0;
            buf_wr_ptr_q <= 1'b0;
            buf_rd_ptr_q <= 1'b0;
        end else begin
            rd_prio_q    <= rd_prio_d;
            buf_count_q  <= buf_count_d;
            buf_wr_ptr_q <= buf_wr_ptr_q ^ push_s;
            buf_rd_ptr_q <= buf_rd_ptr_q ^ pop_s;
        end
    end

    // FIFO payload storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            buf_data_q[buf_wr_ptr_q] <= sram_data_out_i;
            buf_id_q[buf_wr_ptr_q]   <= push_id_s;
        end
    end

    assign rsp_valid_o = (buf_count_q != 2'd0);
    assign rsp_data_o  = buf_data_q[buf_rd_ptr_q];
    assign rsp_id_o    = buf_id_q[buf_rd_ptr_q];
    assign busy_o      = inflight_s || (buf_count_q != 2'd0);

endmodule

// File: tb/tb_hnf_sram_ctl.sv
module tb_hnf_sram_ctl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wv, rv, rr;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [IW-1:0] id;

    // Zero-latency instance outputs
    logic          wrr0, rdr0, rspv0, we0, busy0;
    logic [DW-1:0] rdata0, din0, dout0;
    logic [IW-1:0] rid0;
    logic [AW-1:0] addr0;
    // One-cycle-latency instance outputs
    logic          wrr1, rdr1, rspv1, we1, busy1;
    logic [DW-1:0] rdata1, din1, dout1;
    logic [IW-1:0] rid1;
    logic [AW-1:0] addr1;

    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hnf_sram_ctl #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RD_ID_WIDTH(IW), .RD_LATENCY(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wv), .wr_ready_o(wrr0), .wr_addr_i(wa), .wr_data_i(wd),
        .rd_valid_i(rv), .rd_ready_o(rdr0), .rd_addr_i(ra), .rd_id_i(id),
        .rsp_valid_o(rspv0), .rsp_ready_i(rr), .rsp_data_o(rdata0), .rsp_id_o(rid0),
        .sram_we_o(we0), .sram_addr_o(addr0), .sram_data_in_o(din0), .sram_data_out_i(dout0),
        .busy_o(busy0));

    hnf_sram_ctl #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RD_ID_WIDTH(IW), .RD_LATENCY(1)) u1 (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wv), .wr_ready_o(wrr1), .wr_addr_i(wa), .wr_data_i(wd),
        .rd_valid_i(rv), .rd_ready_o(rdr1), .rd_addr_i(ra), .rd_id_i(id),
        .rsp_valid_o(rspv1), .rsp_ready_i(rr), .rsp_data_o(rdata1), .rsp_id_o(rid1),
        .sram_we_o(we1), .sram_addr_o(addr1), .sram_data_in_o(din1), .sram_data_out_i(dout1),
        .busy_o(busy1));

    // SRAM models: asynchronous read for latency 0, registered read for latency 1.
    always @(posedge clk) if (we0) mem0[addr0] <= din0;
    always_comb dout0 = mem0[addr0];
    always @(posedge clk) begin
        if (we1) mem1[addr1] <= din1;
        dout1 <= mem1[addr1];
    end

    typedef struct {
        logic          wv, rv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [IW-1:0] id;
        logic          rr;
        logic          e_wrr, e_rdr, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_rspv;
        logic [IW-1:0] e_rid;
        logic [DW-1:0] e_rdata;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [AW-1:0] a_w, input logic [DW-1:0] d_w,
                         input logic [AW-1:0] a_r, input logic [IW-1:0] i_r, input logic rdy);
        wv = w; rv = r; wa = a_w; wd = d_w; ra = a_r; id = i_r; rr = rdy;
    endtask

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h05, 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b1);

        // Write/read-after-write, then held conflict, then backpressure with write stream.
        add('{1'b1,1'b0,8'h10,32'hAAAA_AAAA,8'h00,8'h00,1'b1, 1'b1,1'b0,1'b1,8'h10,32'hAAAA_AAAA, 1'b0,8'h00,32'h0,1'b0});
        add('{1'b0,1'b1,8'h00,32'h0,8'h10,8'h03,1'b1, 1'b0,1'b1,1'b0,8'h10,32'h0, 1'b0,8'h00,32'h0,1'b0});
        add('{1'b0,1'b0,8'h00,32'h0,8'h00,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,32'h0, 1'b1,8'h03,32'hAAAA_AAAA,1'b1});
        add('{1'b1,1'b1,8'h20,32'h1111_1111,8'h10,8'h04,1'b1, 1'b0,1'b1,1'b0,8'h10,32'h0, 1'b0,8'h00,32'h0,1'b0});
        add('{1'b1,1'b1,8'h20,32'h1111_1111,8'h10,8'h04,1'b1, 1'b1,1'b0,1'b1,8'h20,32'h1111_1111, 1'b1,8'h04,32'hAAAA_AAAA,1'b1});
        add('{1'b1,1'b1,8'h20,32'h1111_1111,8'h10,8'h04,1'b1, 1'b0,1'b1,1'b0,8'h10,32'h0, 1'b0,8'h00,32'h0,1'b0});
        add('{1'b1,1'b1,8'h20,32'h1111_1111,8'h10,8'h04,1'b1, 1'b1,1'b0,1'b1,8'h20,32'h1111_1111, 1'b1,8'h04,32'hAAAA_AAAA,1'b1});
        add('{1'b0,1'b1,8'h00,32'h0,8'h20,8'h05,1'b0, 1'b0,1'b1,1'b0,8'h20,32'h0, 1'b0,8'h00,32'h0,1'b0});
        add('{1'b0,1'b1,8'h00,32'h0,8'h20,8'h06,1'b0, 1'b0,1'b1,1'b0,8'h20,32'h0, 1'b1,8'h05,32'h1111_1111,1'b1});
        add('{1'b0,1'b1,8'h00,32'h0,8'h20,8'h07,1'b0, 1'b0,1'b0,1'b0,8'h00,32'h0, 1'b1,8'h05,32'h1111_1111,1'b1});
        add('{1'b1,1'b1,8'h30,32'h2222_2222,8'h20,8'h07,1'b0, 1'b1,1'b0,1'b1,8'h30,32'h2222_2222, 1'b1,8'h05,32'h1111_1111,1'b1});
        add('{1'b1,1'b1,8'h31,32'h3333_3333,8'h20,8'h07,1'b0, 1'b1,1'b0,1'b1,8'h31,32'h3333_3333, 1'b1,8'h05,32'h1111_1111,1'b1});
        add('{1'b0,1'b1,8'h00,32'h0,8'h20,8'h07,1'b1, 1'b0,1'b0,1'b0,8'h00,32'h0, 1'b1,8'h05,32'h1111_1111,1'b1});
        add('{1'b0,1'b1,8'h00,32'h0,8'h20,8'h07,1'b1, 1'b0,1'b1,1'b0,8'h20,32'h0, 1'b1,8'h06,32'h1111_1111,1'b1});
        add('{1'b0,1'b1,8'h00,32'h0,8'h30,8'h08,1'b1, 1'b0,1'b1,1'b0,8'h30,32'h0, 1'b1,8'h07,32'h1111_1111,1'b1});
        add('{1'b0,1'b0,8'h00,32'h0,8'h00,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,32'h0, 1'b1,8'h08,32'h2222_2222,1'b1});
        add('{1'b0,1'b0,8'h00,32'h0,8'h00,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h00,32'h0, 1'b0,8'h00,32'h0,1'b0});

        // Reset state, with a write request held to show SRAM_WE is suppressed.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("rst_we0", {31'b0, we0}, 32'd0);
            chk("rst_we1", {31'b0, we1}, 32'd0);
            chk("rst_rspv0", {31'b0, rspv0}, 32'd0);
            chk("rst_busy0", {31'b0, busy0}, 32'd0);
            chk("rst_busy1", {31'b0, busy1}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Table-driven cycles on the zero-latency instance.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].wv, vecs[i].rv, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].id, vecs[i].rr);
            #1;
            chk($sformatf("v%0d_wr_ready", i), {31'b0, wrr0}, {31'b0, vecs[i].e_wrr});
            chk($sformatf("v%0d_rd_ready", i), {31'b0, rdr0}, {31'b0, vecs[i].e_rdr});
            chk($sformatf("v%0d_sram_we", i), {31'b0, we0}, {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_sram_addr", i), {24'b0, addr0}, {24'b0, vecs[i].e_addr});
            if (vecs[i].e_we) chk($sformatf("v%0d_sram_din", i), din0, vecs[i].e_din);
            chk($sformatf("v%0d_rsp_valid", i), {31'b0, rspv0}, {31'b0, vecs[i].e_rspv});
            chk($sformatf("v%0d_busy", i), {31'b0, busy0}, {31'b0, vecs[i].e_busy});
            if (vecs[i].e_rspv) begin
                chk($sformatf("v%0d_rsp_id", i), {24'b0, rid0}, {24'b0, vecs[i].e_rid});
                chk($sformatf("v%0d_rsp_data", i), rdata0, vecs[i].e_rdata);
            end
        end

        // One-cycle latency: write then read same address, response two cycles after the read.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 32'hAAAA_AAAA, 8'h00, 8'h00, 1'b1);
        #1 chk("l1_wr_ready", {31'b0, wrr1}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h00, 32'h0, 8'h10, 8'h03, 1'b1);
        #1 chk("l1_rd_ready", {31'b0, rdr1}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 8'h00, 1'b1);
        #1;
        chk("l1_rspv_early", {31'b0, rspv1}, 32'd0);
        chk("l1_busy_inflight", {31'b0, busy1}, 32'd1);
        @(negedge clk); #1;
        chk("l1_rspv", {31'b0, rspv1}, 32'd1);
        chk("l1_rsp_id", {24'b0, rid1}, 32'd3);
        chk("l1_rsp_data", rdata1, 32'hAAAA_AAAA);
        @(negedge clk); #1;
        chk("l1_drained", {31'b0, busy1}, 32'd0);

        // Reset one cycle after a read grant discards the in-flight read.
        drive(1'b0, 1'b1, 8'h00, 32'h0, 8'h10, 8'h09, 1'b0);
        #1 chk("l1_rst_rd_ready", {31'b0, rdr1}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("l1_post_rst_rspv%0d", c), {31'b0, rspv1}, 32'd0);
            chk($sformatf("l1_post_rst_busy%0d", c), {31'b0, busy1}, 32'd0);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
